// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Passive tracer on the writeback stage of the 5-stage pipeline. Each
// retirement is stored as one record {PC, instruction, writeback data} in a
// DEPTH-entry FIFO. Records leave as three 32-bit words on a valid/ready
// stream: PC, then instruction, then data (out_last marks the data word).
// The buffer never stalls the core. A record that arrives while the FIFO is
// full is dropped, and the sticky overflow flag is set. Capturing HALT_INST
// sets the sticky halted flag, and every later retirement is then ignored.
// All stream outputs come straight from registers, so there is no
// combinational path from wb_* to out_*.
module wb_trace_buffer #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] HALT_INST = 32'h00000033
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid_i,
  input  logic [31:0]              wb_pc_i,
  input  logic [31:0]              wb_inst_i,
  input  logic [31:0]              wb_data_i,
  input  logic                     wb_regwen_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     halted,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_COUNT = CW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Position of the head record's word that is currently on the stream.
  typedef enum logic [1:0] {
    WORD_PC   = 2'd0,
    WORD_INST = 2'd1,
    WORD_DATA = 2'd2
  } word_state_t;

  // Choose one of the three record fields based on the word position.
  function automatic logic [31:0] select_word(
    input word_state_t sel,
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic [31:0] data
  );
    logic [31:0] w;
    case (sel)
      WORD_PC:   w = pc;
      WORD_INST: w = inst;
      WORD_DATA: w = data;
      default:   w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Record storage. It is not reset, because occupancy is tracked by count_r.
  logic [31:0] pc_mem_r   [DEPTH];
  logic [31:0] inst_mem_r [DEPTH];
  logic [31:0] data_mem_r [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  word_state_t   word_r;
  logic          halted_r;
  logic          overflow_r;
  logic          out_valid_r;
  logic [31:0]   out_data_r;
  logic          out_last_r;

  logic          xfer_s;
  logic          pop_s;
  logic          full_s;
  logic          accept_s;
  logic          push_s;
  logic          drop_s;
  logic          halt_seen_s;
  logic          bypass_s;
  logic [31:0]   store_data_s;
  logic [CW-1:0] count_nxt_s;
  logic [AW-1:0] wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_nxt_s;
  word_state_t   word_nxt_s;
  logic [31:0]   head_pc_s;
  logic [31:0]   head_inst_s;
  logic [31:0]   head_data_s;
  logic          out_valid_nxt_s;
  logic [31:0]   out_data_nxt_s;
  logic          out_last_nxt_s;

  // Handshake, push/pop/drop decisions and the halt detection.
  always_comb begin
    xfer_s       = out_valid_r & out_ready;
    pop_s        = xfer_s & (word_r == WORD_DATA);
    full_s       = (count_r == FULL_COUNT);
    accept_s     = wb_valid_i & ~halted_r;
    push_s       = accept_s & (~full_s | pop_s);
    drop_s       = accept_s & full_s & ~pop_s;
    halt_seen_s  = accept_s & (wb_inst_i == HALT_INST);
    store_data_s = wb_regwen_i ? wb_data_i : 32'h0000_0000;
  end

  // Next pointers and occupancy. A simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_COUNT;
      2'b01:   count_nxt_s = count_r - ONE_COUNT;
      default: count_nxt_s = count_r;
    endcase
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Word-position FSM next state: PC -> INST -> DATA -> PC, advancing on each transfer.
  always_comb begin
    word_nxt_s = word_r;
    if (xfer_s) begin
      case (word_r)
        WORD_PC:   word_nxt_s = WORD_INST;
        WORD_INST: word_nxt_s = WORD_DATA;
        WORD_DATA: word_nxt_s = WORD_PC;
        default:   word_nxt_s = WORD_PC;
      endcase
    end else begin
      word_nxt_s = word_r;
    end
  end

  // Next stream word. If the next head is the record being written on this
  // edge, the incoming fields are forwarded, because storage is not yet updated.
  always_comb begin
    bypass_s = push_s & ((count_r == ZERO_COUNT) | ((count_r == ONE_COUNT) & pop_s));
    if (bypass_s) begin
      head_pc_s   = wb_pc_i;
      head_inst_s = wb_inst_i;
      head_data_s = store_data_s;
    end else begin
      head_pc_s   = pc_mem_r[rd_ptr_nxt_s];
      head_inst_s = inst_mem_r[rd_ptr_nxt_s];
      head_data_s = data_mem_r[rd_ptr_nxt_s];
    end
    out_valid_nxt_s = (count_nxt_s != ZERO_COUNT);
    if (out_valid_nxt_s) begin
      out_data_nxt_s = select_word(word_nxt_s, head_pc_s, head_inst_s, head_data_s);
      out_last_nxt_s = (word_nxt_s == WORD_DATA);
    end else begin
      out_data_nxt_s = 32'h0000_0000;
      out_last_nxt_s = 1'b0;
    end
  end

  // Record storage write on capture.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= wb_pc_i;
      inst_mem_r[wr_ptr_r] <= wb_inst_i;
      data_mem_r[wr_ptr_r] <= store_data_s;
    end
  end

  // FIFO control state, the word-position FSM and the sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_COUNT;
      word_r     <= WORD_PC;
      halted_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      word_r     <= word_nxt_s;
      halted_r   <= halted_r | halt_seen_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Registered stream outputs. They hold steady under backpressure because their inputs do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_last_r  <= out_last_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign halted    = halted_r;
  assign overflow  = overflow_r;
  assign count     = count_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer. A queue-based reference model
// tracks records, the drain word position and the sticky flags. It is
// updated once per clock edge from the driven inputs.
module tb_wb_trace_buffer;

  localparam int          DEPTH = 16;
  localparam logic [31:0] HALT  = 32'h00000033;

  logic        clk;
  logic        rst;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic [31:0] wb_inst_i;
  logic [31:0] wb_data_i;
  logic        wb_regwen_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        halted;
  logic        overflow;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] data;
  } rec_t;

  rec_t mq[$];
  int   m_widx;
  bit   m_halted;
  bit   m_overflow;

  wb_trace_buffer #(.DEPTH(DEPTH), .HALT_INST(HALT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i), .wb_inst_i(wb_inst_i),
    .wb_data_i(wb_data_i), .wb_regwen_i(wb_regwen_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .halted(halted), .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_data();
    if (mq.size() == 0) return 32'h0;
    case (m_widx)
      0:       return mq[0].pc;
      1:       return mq[0].inst;
      default: return mq[0].data;
    endcase
  endfunction

  function automatic logic exp_last();
    return (mq.size() != 0) && (m_widx == 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_widx     = 0;
    m_halted   = 1'b0;
    m_overflow = 1'b0;
  endtask

  // The reference model advances by one clock edge, using the inputs held across that edge.
  task automatic model_edge();
    bit   hs, pop, was_full;
    rec_t r;
    hs       = (mq.size() != 0) && (out_ready === 1'b1);
    pop      = hs && (m_widx == 2);
    was_full = (mq.size() >= DEPTH);
    if (hs) m_widx = (m_widx == 2) ? 0 : m_widx + 1;
    if (pop) void'(mq.pop_front());
    if (wb_valid_i && !m_halted) begin
      if (!was_full || pop) begin
        r.pc   = wb_pc_i;
        r.inst = wb_inst_i;
        r.data = wb_regwen_i ? wb_data_i : 32'h0;
        mq.push_back(r);
      end else begin
        m_overflow = 1'b1;
      end
      if (wb_inst_i == HALT) m_halted = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_rec(input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] data, input logic regwen);
    wb_valid_i  = 1'b1;
    wb_pc_i     = pc;
    wb_inst_i   = inst;
    wb_data_i   = data;
    wb_regwen_i = regwen;
  endtask

  task automatic do_reset();
    wb_valid_i = 1'b0;
    out_ready  = 1'b0;
    rst = 1'b1;
    #3;
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0 ||
        halted !== 1'b0 || overflow !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b d=%h h=%b o=%b c=%0d, want all 0",
               out_valid, out_last, out_data, halted, overflow, count);
    end
    for (int i = 0; i < 3; i++) begin
      drive_rec(32'h200 + 32'(i * 4), 32'h00000013, 32'h0000_0010 + 32'(i), 1'b1);
      tick();
    end
    wb_valid_i = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    checks++;
    if (count !== 5'd3 || out_data !== 32'h00000013) begin
      errors++;
      $display("FAIL reset_prefill: got c=%0d d=%h, want c=3 d=00000013", count, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0 || halted !== 1'b0 ||
        overflow !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b c=%0d h=%b o=%b d=%h l=%b, want all 0",
               out_valid, count, halted, overflow, out_data, out_last);
    end
    model_reset();
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_residual: got v=%b c=%0d, want v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_w [3];
    logic [31:0] got_w [3];
    logic        got_l [3];
    int          n;
    exp_w[0] = 32'h00000004;
    exp_w[1] = 32'h00500093;
    exp_w[2] = 32'h00000005;
    do_reset();
    out_ready = 1'b1;
    drive_rec(32'h00000004, 32'h00500093, 32'h00000005, 1'b1);
    tick();
    wb_valid_i = 1'b0;
    checks++;
    if (count !== 5'd1 || out_valid !== 1'b1 || out_data !== 32'h4) begin
      errors++;
      $display("FAIL single_latency: got c=%0d v=%b d=%h, want c=1 v=1 d=00000004",
               count, out_valid, out_data);
    end
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      if (out_valid === 1'b1) begin
        got_w[n] = out_data;
        got_l[n] = out_last;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL single_words: got %0d words, want 3", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 2)) begin
        errors++;
        $display("FAIL single_word%0d: got d=%h l=%b, want d=%h l=%b",
                 i, got_w[i], got_l[i], exp_w[i], (i == 2));
      end
    end
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got c=%0d v=%b, want c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_w [3];
    int          n;
    do_reset();
    drive_rec(32'h00000004, 32'h00112023, 32'h0000DEAD, 1'b0);
    tick();
    wb_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00000004 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got v=%b d=%h l=%b, want v=1 d=00000004 l=0",
                 c, out_valid, out_data, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      if (out_valid === 1'b1) begin
        got_w[n] = out_data;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3 || got_w[1] !== 32'h00112023 || got_w[2] !== 32'h00000000) begin
      errors++;
      $display("FAIL regwen0_data: got n=%0d w1=%h w2=%h, want n=3 w1=00112023 w2=00000000",
               n, got_w[1], got_w[2]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] pcs[$];
    int          k;
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_rec(32'h1000 + 32'(i * 4), 32'h00000013 | (32'(i) << 20), 32'(i), 1'b1);
      tick();
    end
    wb_valid_i = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || out_data !== 32'h1000) begin
      errors++;
      $display("FAIL full_state: got c=%0d o=%b d=%h, want c=16 o=1 d=00001000",
               count, overflow, out_data);
    end
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && out_valid === 1'b1; c++) begin
      if (k % 3 == 0) pcs.push_back(out_data);
      k++;
      tick();
    end
    checks++;
    if (pcs.size() != DEPTH || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_drain_len: got %0d records o=%b, want 16 o=1", pcs.size(), overflow);
    end
    for (int i = 0; i < pcs.size(); i++) begin
      checks++;
      if (pcs[i] !== 32'h1000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL full_drain_pc%0d: got %h, want %h", i, pcs[i], 32'h1000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] pcs[$];
    int          k;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_rec(32'h3000 + 32'(i * 4), 32'h00000013, 32'(i), 1'b1);
      tick();
    end
    wb_valid_i = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    checks++;
    if (out_last !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL ppf_setup: got l=%b c=%0d, want l=1 c=16", out_last, count);
    end
    drive_rec(32'h0000ABC0, 32'h00000013, 32'h0, 1'b1);
    tick();
    wb_valid_i = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ppf_count: got c=%0d o=%b, want c=16 o=0", count, overflow);
    end
    k = 0;
    for (int c = 0; c < 200 && out_valid === 1'b1; c++) begin
      if (k % 3 == 0) pcs.push_back(out_data);
      k++;
      tick();
    end
    checks++;
    if (pcs.size() != DEPTH || pcs[pcs.size() - 1] !== 32'h0000ABC0) begin
      errors++;
      $display("FAIL ppf_last_pc: got n=%0d last=%h, want n=16 last=0000abc0",
               pcs.size(), (pcs.size() != 0) ? pcs[pcs.size() - 1] : 32'h0);
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_w [6];
    logic [31:0] got_w [6];
    int          n;
    exp_w[0] = 32'h00000040; exp_w[1] = 32'h00100093; exp_w[2] = 32'h00000011;
    exp_w[3] = 32'h00000044; exp_w[4] = 32'h00000033; exp_w[5] = 32'h00000000;
    do_reset();
    drive_rec(32'h40, 32'h00100093, 32'h11, 1'b1);
    tick();
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: got h=%b, want 0", halted);
    end
    drive_rec(32'h44, 32'h00000033, 32'h77, 1'b0);
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_set: got h=%b, want 1", halted);
    end
    drive_rec(32'h48, 32'h00200113, 32'h22, 1'b1);
    tick();
    wb_valid_i = 1'b0;
    checks++;
    if (count !== 5'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignore: got c=%0d o=%b, want c=2 o=0", count, overflow);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      if (out_valid === 1'b1) begin
        got_w[n] = out_data;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 6 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_drain_len: got n=%0d v=%b, want n=6 v=0", n, out_valid);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL halt_word%0d: got %h, want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_random();
    int ready_pct;
    int valid_pct;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      ready_pct = 30 + round * 25;
      valid_pct = 70 - round * 15;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        wb_valid_i  = ($urandom_range(0, 99) < valid_pct);
        wb_pc_i     = $urandom;
        wb_inst_i   = ($urandom_range(0, 399) == 0) ? HALT : $urandom;
        wb_data_i   = $urandom;
        wb_regwen_i = $urandom_range(0, 1);
        out_ready   = ($urandom_range(0, 99) < ready_pct);
        tick();
        checks++;
        if (out_valid !== (mq.size() != 0) || out_data !== exp_data() ||
            out_last !== exp_last() || count !== 5'(mq.size()) ||
            halted !== m_halted || overflow !== m_overflow) begin
          errors++;
          $display("FAIL random r%0d cyc%0d: got v=%b d=%h l=%b c=%0d h=%b o=%b, want v=%b d=%h l=%b c=%0d h=%b o=%b",
                   round, cyc, out_valid, out_data, out_last, count, halted, overflow,
                   (mq.size() != 0), exp_data(), exp_last(), mq.size(), m_halted, m_overflow);
        end
      end
    end
    wb_valid_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    wb_valid_i  = 1'b0;
    wb_pc_i     = 32'h0;
    wb_inst_i   = 32'h0;
    wb_data_i   = 32'h0;
    wb_regwen_i = 1'b0;
    out_ready   = 1'b0;
    model_reset();
    #12;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
